// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared opcode/state types and PC width for the PC sequencer
package pc_seq_pkg;
  localparam int PC_W = 16;
  typedef enum logic [2:0] {
    NOP    = 3'd0,
    JNEAR  = 3'd1,
    JREALM = 3'd2,
    JFAR   = 3'd3,
    CALL   = 3'd4,
    RET    = 3'd5
  } op_t;
  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;
endpackage

// File: rtl/return_stack.sv
// return_stack: LIFO of return addresses with combinational top and synchronous clear
module return_stack
  import pc_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] top,
  output logic            full,
  output logic            empty,
  output logic [AW:0]     count
);
  logic [PC_W-1:0] mem [DEPTH];
  logic [AW:0]     sp;
  assign full  = sp == (AW+1)'(DEPTH);
  assign empty = sp == '0;
  assign count = sp;
  assign top   = mem[AW'(sp - 1'b1)];
  always_ff @(posedge clk or posedge rst)
    if (rst) sp <= '0;
    else if (clear) sp <= '0;
    else if (push && !full) sp <= sp + 1'b1;
    else if (pop && !empty) sp <= sp - 1'b1;
  // storage needs no reset: entries above sp are never observed
  always_ff @(posedge clk)
    if (push && !full && !clear) mem[sp[AW-1:0]] <= din;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: turns execute-stage branch requests into same-cycle PC control,
// with a return-address stack for far calls and returns
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int STACK_DEPTH = 8
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         start,
  input  logic                         clear_fault,
  input  logic                         fetch_ready,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [2:0]                   req_op,
  input  logic [15:0]                  req_target,
  input  logic [15:0]                  pc_addr,
  output logic                         pc_enable,
  output logic                         pc_cjmp,
  output logic                         pc_rjmp,
  output logic [7:0]                   pc_rx_count,
  output logic [7:0]                   pc_rx_realm,
  output logic                         running,
  output logic                         fault,
  output logic                         overflow,
  output logic                         underflow,
  output logic [$clog2(STACK_DEPTH):0] depth
);
  state_t          state, state_n;
  op_t             op;
  logic [PC_W-1:0] top;
  logic            full, empty, accept, is_call, is_ret, ovf, unf, clr;
  assign op        = op_t'(req_op);
  assign running   = state == RUN;
  assign fault     = state == FAULT;
  assign req_ready = running & fetch_ready;
  assign accept    = req_ready & req_valid;
  assign is_call   = accept && op == CALL;
  assign is_ret    = accept && op == RET;
  assign ovf       = is_call && full;
  assign unf       = is_ret && empty;
  assign clr       = fault & clear_fault;
  assign pc_enable = req_ready & ~(ovf | unf);
  return_stack #(.DEPTH(STACK_DEPTH)) u_stack (
    .clk   (aclk),
    .rst   (areset),
    .clear (clr),
    .push  (is_call && !full),
    .pop   (is_ret && !empty),
    .din   (pc_addr),
    .top   (top),
    .full  (full),
    .empty (empty),
    .count (depth)
  );
  always_comb begin
    pc_cjmp     = 1'b0;
    pc_rjmp     = 1'b0;
    pc_rx_count = 8'h00;
    pc_rx_realm = 8'h00;
    if (accept && !ovf && !unf)
      case (op)
        JNEAR: begin
          pc_cjmp     = 1'b1;
          pc_rx_count = req_target[7:0];
        end
        JREALM: begin
          pc_rjmp     = 1'b1;
          pc_rx_realm = req_target[15:8];
        end
        JFAR, CALL: begin
          pc_cjmp                    = 1'b1;
          pc_rjmp                    = 1'b1;
          {pc_rx_realm, pc_rx_count} = req_target;
        end
        RET: begin
          pc_cjmp                    = 1'b1;
          pc_rjmp                    = 1'b1;
          {pc_rx_realm, pc_rx_count} = top;
        end
        default: ;
      endcase
  end
  always_comb begin
    state_n = (state == IDLE && start)         ? RUN   :
              (state == RUN && (ovf || unf))   ? FAULT :
              clr                              ? IDLE  : state;
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf) overflow <= 1'b1;
      if (unf) underflow <= 1'b1;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: reference-model scoreboard plus directed checks for pc_sequencer
module tb_pc_sequencer;
  import pc_seq_pkg::*;
  logic        aclk = 1'b0;
  logic        areset, start, clear_fault, fetch_ready, req_valid;
  logic        req_ready, pc_enable, pc_cjmp, pc_rjmp;
  logic [2:0]  req_op;
  logic [15:0] req_target, pc_addr;
  logic [7:0]  pc_rx_count, pc_rx_realm;
  logic        running, fault, overflow, underflow;
  logic [3:0]  depth;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb [$];
  int          m_state, m_sp;
  logic [15:0] m_stk [8];
  bit          m_ovf, m_unf;

  always #5 aclk = ~aclk;

  pc_sequencer #(.STACK_DEPTH(8)) dut (
    .aclk        (aclk),
    .areset      (areset),
    .start       (start),
    .clear_fault (clear_fault),
    .fetch_ready (fetch_ready),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_target  (req_target),
    .pc_addr     (pc_addr),
    .pc_enable   (pc_enable),
    .pc_cjmp     (pc_cjmp),
    .pc_rjmp     (pc_rjmp),
    .pc_rx_count (pc_rx_count),
    .pc_rx_realm (pc_rx_realm),
    .running     (running),
    .fault       (fault),
    .overflow    (overflow),
    .underflow   (underflow),
    .depth       (depth)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack(input logic en, cj, rj, input logic [7:0] cnt, rlm,
                                       input logic rdy, run, flt, ov, un, input logic [3:0] dep);
    return {4'h0, en, cj, rj, cnt, rlm, rdy, run, flt, ov, un, dep};
  endfunction

  function automatic logic [31:0] expect_out();
    logic run, flt, rdy, acc, bad, cj, rj;
    logic [7:0] cnt, rlm;
    run = m_state == 1;
    flt = m_state == 2;
    rdy = run && fetch_ready;
    acc = rdy && req_valid;
    bad = acc && ((req_op == 3'd4 && m_sp == 8) || (req_op == 3'd5 && m_sp == 0));
    cj = 0; rj = 0; cnt = 0; rlm = 0;
    if (acc && !bad)
      case (req_op)
        3'd1: begin cj = 1; cnt = req_target[7:0]; end
        3'd2: begin rj = 1; rlm = req_target[15:8]; end
        3'd3, 3'd4: begin cj = 1; rj = 1; {rlm, cnt} = req_target; end
        3'd5: begin cj = 1; rj = 1; {rlm, cnt} = m_stk[m_sp-1]; end
        default: ;
      endcase
    return pack(rdy && !bad, cj, rj, cnt, rlm, rdy, run, flt, m_ovf, m_unf, 4'(m_sp));
  endfunction

  task automatic model_step();
    logic acc;
    acc = m_state == 1 && fetch_ready && req_valid;
    if (areset) begin
      m_state = 0; m_sp = 0; m_ovf = 0; m_unf = 0;
    end else if (m_state == 0) begin
      if (start) m_state = 1;
    end else if (m_state == 2) begin
      if (clear_fault) begin m_state = 0; m_sp = 0; m_ovf = 0; m_unf = 0; end
    end else if (acc && req_op == 3'd4) begin
      if (m_sp == 8) begin m_ovf = 1; m_state = 2; end
      else begin m_stk[m_sp] = pc_addr; m_sp++; end
    end else if (acc && req_op == 3'd5) begin
      if (m_sp == 0) begin m_unf = 1; m_state = 2; end
      else m_sp--;
    end
  endtask

  task automatic cyc(input logic st, cf, fr, v, input logic [2:0] op,
                     input logic [15:0] t, pc);
    @(posedge aclk);
    model_step();
    #1;
    start = st; clear_fault = cf; fetch_ready = fr; req_valid = v;
    req_op = op; req_target = t; pc_addr = pc;
    sb.push_back(expect_out());
  endtask

  always @(negedge aclk)
    if (sb.size() > 0)
      chk("scoreboard", pack(pc_enable, pc_cjmp, pc_rjmp, pc_rx_count, pc_rx_realm, req_ready,
                             running, fault, overflow, underflow, depth), sb.pop_front());

  initial begin
    areset = 1; start = 0; clear_fault = 0; fetch_ready = 0; req_valid = 0;
    req_op = 0; req_target = 0; pc_addr = 0;
    m_state = 0; m_sp = 0; m_ovf = 0; m_unf = 0;
    repeat (2) cyc(0, 0, 0, 0, NOP, 0, 0);
    #5 chk("rst_en", pc_enable, 0); chk("rst_depth", depth, 0); chk("rst_run", running, 0);
    areset = 0;
    cyc(1, 0, 1, 0, NOP, 0, 0);
    cyc(0, 0, 1, 0, NOP, 0, 0);
    #5 chk("run_en", pc_enable, 1); chk("run_rdy", req_ready, 1); chk("run_jmp", {pc_cjmp, pc_rjmp}, 0);
    repeat (2) begin
      cyc(0, 0, 0, 1, JFAR, 16'h1234, 0);
      #5 chk("stall_rdy", req_ready, 0);
    end
    cyc(0, 0, 1, 1, JFAR, 16'h1234, 0);
    #5 chk("jfar", {pc_cjmp, pc_rjmp, pc_rx_realm, pc_rx_count}, {2'b11, 16'h1234});
    cyc(0, 0, 1, 1, JNEAR, 16'hAB56, 0);
    #5 chk("jnear", {pc_cjmp, pc_rjmp, pc_rx_realm, pc_rx_count}, {2'b10, 16'h0056});
    cyc(0, 0, 1, 1, 3'd7, 16'hFFFF, 0);
    #5 chk("rsvd", {pc_enable, pc_cjmp, pc_rjmp, pc_rx_realm, pc_rx_count}, {3'b100, 16'h0000});
    cyc(0, 0, 1, 1, CALL, 16'h0500, 16'h0207);
    #5 chk("call", {pc_cjmp, pc_rjmp, pc_rx_realm, pc_rx_count}, {2'b11, 16'h0500});
    cyc(0, 0, 1, 0, NOP, 0, 0);
    #5 chk("depth1", depth, 1);
    cyc(0, 0, 1, 1, RET, 16'hDEAD, 16'h0501);
    #5 chk("ret", {pc_cjmp, pc_rjmp, pc_rx_realm, pc_rx_count}, {2'b11, 16'h0207});
    cyc(0, 0, 1, 0, NOP, 0, 0);
    #5 chk("depth0", depth, 0);
    for (int i = 0; i < 9; i++) cyc(0, 0, 1, 1, CALL, 16'h0100 * 16'(i), 16'h1000 + 16'(i));
    #5 chk("ovf_en", pc_enable, 0); chk("ovf_jmp", {pc_cjmp, pc_rjmp}, 0); chk("ovf_depth", depth, 8);
    cyc(0, 0, 1, 0, NOP, 0, 0);
    #5 chk("ovf_flag", overflow, 1); chk("ovf_fault", fault, 1); chk("fault_rdy", req_ready, 0);
    cyc(0, 1, 1, 0, NOP, 0, 0);
    cyc(0, 0, 1, 0, NOP, 0, 0);
    #5 chk("clr_depth", depth, 0); chk("clr_ovf", overflow, 0); chk("clr_state", {running, fault}, 0);
    cyc(1, 0, 1, 0, NOP, 0, 0);
    cyc(0, 0, 1, 1, RET, 16'h4444, 16'h0123);
    #5 chk("unf_en", pc_enable, 0); chk("unf_jmp", {pc_cjmp, pc_rjmp}, 0);
    cyc(0, 0, 1, 0, NOP, 0, 0);
    #5 chk("unf_flag", {underflow, fault}, 2'b11);
    cyc(0, 1, 1, 0, NOP, 0, 0);
    cyc(1, 0, 1, 0, NOP, 0, 0);
    cyc(0, 0, 1, 1, CALL, 16'h0400, 16'h0300);
    #5 chk("call2", {pc_cjmp, pc_rjmp, pc_rx_realm, pc_rx_count}, {2'b11, 16'h0400});
    areset = 1;
    #1 chk("arst_out", {pc_enable, pc_cjmp, pc_rjmp, req_ready, running, fault}, 0);
    chk("arst_depth", depth, 0);
    cyc(0, 0, 1, 1, CALL, 16'h0400, 16'h0300);
    #5 areset = 0;
    cyc(1, 0, 1, 0, NOP, 0, 0);
    cyc(0, 0, 1, 1, JREALM, 16'h7F33, 0);
    #5 chk("jrealm", {pc_cjmp, pc_rjmp, pc_rx_realm, pc_rx_count}, {2'b01, 16'h7F00});
    chk("jrealm_depth", depth, 0);
    repeat (2) cyc(0, 0, 1, 0, NOP, 0, 0);
    #10;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
